// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared constants for the pipeline sequencing controller.
//   - Stop/NoStop stall polarity and RstEnable/RstDisable reset levels
//   - per-stage stall vectors (bit 0 = PC ... bit 5 = WB)
//   - controller state encoding
//   - redirect_pc(): picks the flush target for an exception code
package pipe_ctrl_pkg;

  localparam logic Stop       = 1'b1;
  localparam logic NoStop     = 1'b0;
  localparam logic RstEnable  = 1'b0;
  localparam logic RstDisable = 1'b1;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  typedef enum logic [1:0] {
    PCTRL_IDLE     = 2'd0,
    PCTRL_DIV_WAIT = 2'd1,
    PCTRL_DIV_DONE = 2'd2,
    PCTRL_FLUSH    = 2'd3
  } pctrl_state_e;

  // eret returns to the saved EPC; every other exception goes to the vector.
  function automatic logic [31:0] redirect_pc(input logic [31:0] exc,
                                              input logic [31:0] epc,
                                              input logic [31:0] eret_code,
                                              input logic [31:0] vector);
    return (exc == eret_code) ? epc : vector;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: bundle between the pipeline stages and pipe_ctrl.
//   master : pipeline side (drives stall requests, divider status, exception info)
//   slave  : controller side (drives stall vector, divider handshake, flush/redirect)
interface pipe_ctrl_if;
  logic        stallreq_from_id;
  logic        stallreq_from_ex;
  logic        stallreq_from_mem;
  logic        div_req_i;
  logic        div_ready_i;
  logic [31:0] excepttype_i;
  logic [31:0] cp0_epc_i;
  logic [5:0]  stall_o;
  logic        div_go_o;
  logic        div_cancel_o;
  logic        div_ack_o;
  logic        div_timeout_o;
  logic        flush_o;
  logic [31:0] new_pc_o;

  modport master (
    output stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
           div_req_i, div_ready_i, excepttype_i, cp0_epc_i,
    input  stall_o, div_go_o, div_cancel_o, div_ack_o, div_timeout_o,
           flush_o, new_pc_o
  );

  modport slave (
    input  stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
           div_req_i, div_ready_i, excepttype_i, cp0_epc_i,
    output stall_o, div_go_o, div_cancel_o, div_ack_o, div_timeout_o,
           flush_o, new_pc_o
  );
endinterface

// File: rtl/pipe_ctrl_stall_mux.sv
// pipe_ctrl_stall_mux: combinational priority merge of stall requests.
//   i_en    : 0 forces no stall (core held in reset)
//   i_flush : exception present or flush in progress; overrides everything
//   i_mem / i_div / i_ex / i_id : stall sources, highest to lowest priority
//   o_stall : per-stage stall vector, 1 = Stop
module pipe_ctrl_stall_mux
  import pipe_ctrl_pkg::*;
(
  input  logic       i_en,
  input  logic       i_flush,
  input  logic       i_mem,
  input  logic       i_div,
  input  logic       i_ex,
  input  logic       i_id,
  output logic [5:0] o_stall
);

  always_comb begin
    o_stall = STALL_NONE;
    if (!i_en || i_flush) o_stall = STALL_NONE;
    else if (i_mem)       o_stall = STALL_MEM;
    else if (i_div)       o_stall = STALL_EX;
    else if (i_ex)        o_stall = STALL_EX;
    else if (i_id)        o_stall = STALL_ID;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencing controller for the 5-stage core.
//   clk : core clock, rising edge
//   rst : asynchronous reset, active low
//   bus : pipe_ctrl_if.slave -- stall requests, divider handshake
//         (go/cancel/ack/timeout), exception flush and PC redirect
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DIV_TIMEOUT  = 64,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
  parameter logic [31:0] ERET_CODE    = 32'h0000_000e
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave bus
);

  // Counters start at 0 on entry, so the last allowed cycle is N-1.
  localparam logic [7:0] DIV_LAST   = 8'(DIV_TIMEOUT - 1);
  localparam logic [1:0] FLUSH_LAST = 2'(FLUSH_CYCLES - 1);

  pctrl_state_e r_state, w_next;
  logic [7:0]   r_div_cnt;
  logic [1:0]   r_flush_cnt;
  logic         r_div_go;
  logic         r_div_timeout;
  logic [31:0]  r_new_pc;

  logic         w_exc;
  logic         w_cancel;
  logic         w_tmo_hit;
  logic         w_div_start;
  logic         w_div_stall;
  logic [5:0]   w_stall;

  assign w_exc       = (bus.excepttype_i != ZeroWord);
  assign w_div_stall = ((r_state == PCTRL_IDLE) && bus.div_req_i) ||
                       (r_state == PCTRL_DIV_WAIT);
  // A ready in the same cycle as the timeout counts as a normal completion.
  assign w_tmo_hit   = (r_state == PCTRL_DIV_WAIT) && !w_exc &&
                       !bus.div_ready_i && (r_div_cnt == DIV_LAST);
  assign w_div_start = (r_state == PCTRL_IDLE) && (w_next == PCTRL_DIV_WAIT);

  pipe_ctrl_stall_mux u_stall_mux (
    .i_en    (rst != RstEnable),
    .i_flush (w_exc || (r_state == PCTRL_FLUSH)),
    .i_mem   (bus.stallreq_from_mem),
    .i_div   (w_div_stall),
    .i_ex    (bus.stallreq_from_ex),
    .i_id    (bus.stallreq_from_id),
    .o_stall (w_stall)
  );

  always_comb begin
    w_next   = r_state;
    w_cancel = 1'b0;
    if (w_exc) begin
      w_next   = PCTRL_FLUSH;
      w_cancel = (r_state == PCTRL_DIV_WAIT);
    end else begin
      case (r_state)
        PCTRL_IDLE:     if (bus.div_req_i && !bus.stallreq_from_mem) w_next = PCTRL_DIV_WAIT;
        PCTRL_DIV_WAIT: begin
          if (bus.div_ready_i) begin
            w_next = PCTRL_DIV_DONE;
          end else if (w_tmo_hit) begin
            w_next   = PCTRL_DIV_DONE;
            w_cancel = 1'b1;
          end
        end
        PCTRL_DIV_DONE: w_next = PCTRL_IDLE;
        PCTRL_FLUSH:    if (r_flush_cnt == FLUSH_LAST) w_next = PCTRL_IDLE;
        default:        w_next = PCTRL_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      r_state       <= PCTRL_IDLE;
      r_div_cnt     <= 8'd0;
      r_flush_cnt   <= 2'd0;
      r_div_go      <= 1'b0;
      r_div_timeout <= 1'b0;
      r_new_pc      <= ZeroWord;
    end else begin
      r_state  <= w_next;
      r_div_go <= w_div_start;

      // Saturating; only meaningful while waiting on the divider.
      if (r_state != PCTRL_DIV_WAIT)  r_div_cnt <= 8'd0;
      else if (r_div_cnt != 8'hFF)    r_div_cnt <= r_div_cnt + 8'd1;

      // A fresh exception restarts the flush window.
      if (w_exc || (r_state != PCTRL_FLUSH)) r_flush_cnt <= 2'd0;
      else if (r_flush_cnt != 2'd3)          r_flush_cnt <= r_flush_cnt + 2'd1;

      // Sticky until the next divide is launched.
      if (w_tmo_hit)        r_div_timeout <= 1'b1;
      else if (w_div_start) r_div_timeout <= 1'b0;

      if (w_exc)
        r_new_pc <= redirect_pc(bus.excepttype_i, bus.cp0_epc_i, ERET_CODE, EXC_VECTOR);
    end
  end

  assign bus.stall_o       = w_stall;
  assign bus.div_go_o      = r_div_go;
  assign bus.div_cancel_o  = w_cancel;
  assign bus.div_ack_o     = (r_state == PCTRL_DIV_DONE);
  assign bus.div_timeout_o = r_div_timeout;
  assign bus.flush_o       = (r_state == PCTRL_FLUSH);
  assign bus.new_pc_o      = r_new_pc;

endmodule
